// File: rtl/bullet_launcher_if.sv
// Bullet launcher bus: turret-stage launch parameters, frame timing, keypress
// and collision inputs, plus the bullet state returned to the colour mapper.
interface bullet_launcher_if;
  logic       frame_clk;
  logic [7:0] keycode;
  logic [9:0] init_pos_x;
  logic [9:0] init_pos_y;
  logic [9:0] motion_x;
  logic [9:0] motion_y;
  logic       hit;
  logic [9:0] bullet_x;
  logic [9:0] bullet_y;
  logic       bullet_active;
  logic       ready;
  logic [7:0] shots_fired;

  modport master (
    output frame_clk, keycode, init_pos_x, init_pos_y, motion_x, motion_y, hit,
    input  bullet_x, bullet_y, bullet_active, ready, shots_fired
  );

  modport slave (
    input  frame_clk, keycode, init_pos_x, init_pos_y, motion_x, motion_y, hit,
    output bullet_x, bullet_y, bullet_active, ready, shots_fired
  );
endinterface

// File: rtl/bullet_launcher.sv
// Single-bullet launcher: latches the turret's start position and motion on a
// fire keypress, steps the bullet once per frame, retires it on a screen exit
// or a collision hit, then waits a number of frames before re-arming.
// Optional macro BULLET_GRAVITY_EN adds a periodic +1 to the Y velocity.
//
// state    | meaning
// IDLE     | armed, waiting for a fresh fire keypress
// FLIGHT   | bullet on screen, stepped on each frame tick
// COOLDOWN | bullet retired, counting frame ticks before re-arming
module bullet_launcher #(
  parameter logic [7:0] FIRE_KEY        = 8'h2C,
  parameter int         SPEED           = 2,
  parameter int         X_MAX           = 639,
  parameter int         Y_MAX           = 479,
  parameter int         COOLDOWN_FRAMES = 4
`ifdef BULLET_GRAVITY_EN
  , parameter int       GRAVITY_PERIOD  = 8
`endif
) (
  input  logic           Clk,
  input  logic           Reset,
  bullet_launcher_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FLIGHT, COOLDOWN} state_t;

  localparam logic signed [11:0] SPEED_S = 12'(SPEED);
  localparam logic signed [11:0] X_LIM   = 12'(X_MAX);
  localparam logic signed [11:0] Y_LIM   = 12'(Y_MAX);
  localparam logic [7:0]         CD_LAST = 8'(COOLDOWN_FRAMES);
`ifdef BULLET_GRAVITY_EN
  localparam logic [7:0]         GRAV_LAST = 8'(GRAVITY_PERIOD - 1);
  localparam logic signed [11:0] VY_CAP    = 12'(7 * SPEED);
`endif

  state_t state, state_nxt;
  logic [2:0] fsync;
  logic       frame_tick;
  logic [7:0] key_prev;
  logic       fire_req;

  logic [9:0]        pos_x, pos_y, pos_x_nxt, pos_y_nxt;
  logic signed [11:0] vel_x, vel_y, vel_x_nxt, vel_y_nxt;
  logic              active, active_nxt;
  logic              ready_q, ready_nxt;
  logic [7:0]        shots, shots_nxt;
  logic [7:0]        cd_cnt, cd_nxt;
`ifdef BULLET_GRAVITY_EN
  logic [7:0]        grav_cnt, grav_nxt;
`endif

  logic signed [11:0] mot_x_ext, mot_y_ext, next_x, next_y;
  logic               out_of_bounds;

  // fsync[0..1] resynchronise frame_clk; fsync[2] is the previous value for edge detect
  assign frame_tick = fsync[1] & ~fsync[2];
  assign fire_req   = (bus.keycode == FIRE_KEY) && (key_prev != FIRE_KEY);

  assign mot_x_ext = {{2{bus.motion_x[9]}}, bus.motion_x};
  assign mot_y_ext = {{2{bus.motion_y[9]}}, bus.motion_y};
  assign next_x    = $signed({2'b00, pos_x}) + vel_x;
  assign next_y    = $signed({2'b00, pos_y}) + vel_y;
  assign out_of_bounds = next_x[11] || next_y[11] || (next_x > X_LIM) || (next_y > Y_LIM);

  // Next-state and datapath decisions for the launch / flight / cooldown cycle
  always_comb begin
    state_nxt  = state;
    pos_x_nxt  = pos_x;
    pos_y_nxt  = pos_y;
    vel_x_nxt  = vel_x;
    vel_y_nxt  = vel_y;
    active_nxt = active;
    shots_nxt  = shots;
    cd_nxt     = cd_cnt;
`ifdef BULLET_GRAVITY_EN
    grav_nxt   = grav_cnt;
`endif
    case (state)
      IDLE: begin
        if (fire_req) begin
          vel_x_nxt  = mot_x_ext * SPEED_S;
          vel_y_nxt  = mot_y_ext * SPEED_S;
          pos_x_nxt  = bus.init_pos_x;
          pos_y_nxt  = bus.init_pos_y;
          active_nxt = 1'b1;
          shots_nxt  = shots + 8'd1;
          state_nxt  = FLIGHT;
`ifdef BULLET_GRAVITY_EN
          grav_nxt   = '0;
`endif
        end
      end
      FLIGHT: begin
        // a hit wins over a same-cycle tick so the bullet freezes where it struck
        if (bus.hit || (frame_tick && out_of_bounds)) begin
          active_nxt = 1'b0;
          cd_nxt     = '0;
          if (COOLDOWN_FRAMES == 0) state_nxt = IDLE;
          else                      state_nxt = COOLDOWN;
        end else if (frame_tick) begin
          pos_x_nxt = next_x[9:0];
          pos_y_nxt = next_y[9:0];
`ifdef BULLET_GRAVITY_EN
          // the bumped velocity is used from the following tick onwards
          if (grav_cnt == GRAV_LAST) begin
            grav_nxt = '0;
            if (vel_y < VY_CAP) vel_y_nxt = vel_y + 12'sd1;
          end else begin
            grav_nxt = grav_cnt + 8'd1;
          end
`endif
        end
      end
      COOLDOWN: begin
        if (frame_tick) begin
          cd_nxt = cd_cnt + 8'd1;
          if (cd_cnt + 8'd1 == CD_LAST) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    ready_nxt = (state_nxt == IDLE);
  end

  // State and datapath registers
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      fsync    <= '0;
      key_prev <= '0;
      pos_x    <= '0;
      pos_y    <= '0;
      vel_x    <= '0;
      vel_y    <= '0;
      active   <= 1'b0;
      ready_q  <= 1'b1;
      shots    <= '0;
      cd_cnt   <= '0;
`ifdef BULLET_GRAVITY_EN
      grav_cnt <= '0;
`endif
    end else begin
      state    <= state_nxt;
      fsync    <= {fsync[1:0], bus.frame_clk};
      key_prev <= bus.keycode;
      pos_x    <= pos_x_nxt;
      pos_y    <= pos_y_nxt;
      vel_x    <= vel_x_nxt;
      vel_y    <= vel_y_nxt;
      active   <= active_nxt;
      ready_q  <= ready_nxt;
      shots    <= shots_nxt;
      cd_cnt   <= cd_nxt;
`ifdef BULLET_GRAVITY_EN
      grav_cnt <= grav_nxt;
`endif
    end
  end

  assign bus.bullet_x      = pos_x;
  assign bus.bullet_y      = pos_y;
  assign bus.bullet_active = active;
  assign bus.ready         = ready_q;
  assign bus.shots_fired   = shots;

endmodule

// File: tb/tb_bullet_launcher.sv
// Bench for bullet_launcher: directed launch/flight/hit/cooldown/reset scenario
// with literal expectations, then randomized keys, frames, hits and launch
// parameters checked every cycle against a behavioural model.
module tb_bullet_launcher;
  logic Clk = 1'b0;
  logic Reset = 1'b0;

  bullet_launcher_if bus();

  bullet_launcher dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  always #10 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  // behavioural model: one bullet, cooldown measured in frames still to wait
  int m_x, m_y, m_vx, m_vy, m_shots, m_rest;
  bit m_fly;
  int f1, f2, f3;   // frame_clk as seen at the last three Clk edges
  int pkey;
  bit tick, fire;
  int nx, ny;

  function automatic bit m_ready();
    return !m_fly && (m_rest == 0);
  endfunction

  // model update: a frame tick acts on the edge two after the first edge that sees frame_clk high
  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      m_x = 0; m_y = 0; m_vx = 0; m_vy = 0; m_shots = 0; m_rest = 0; m_fly = 0;
      f1 = 0; f2 = 0; f3 = 0; pkey = 0;
    end else begin
      tick = (f2 == 1) && (f3 == 0);
      f3 = f2; f2 = f1; f1 = int'(bus.frame_clk);
      fire = (bus.keycode == 8'h2C) && (pkey != 8'h2C);
      pkey = int'(bus.keycode);
      if (m_ready()) begin
        if (fire) begin
          m_vx = int'($signed(bus.motion_x)) * 2;
          m_vy = int'($signed(bus.motion_y)) * 2;
          m_x = int'(bus.init_pos_x);
          m_y = int'(bus.init_pos_y);
          m_fly = 1;
          m_shots = (m_shots + 1) % 256;
        end
      end else if (m_fly) begin
        if (bus.hit) begin
          m_fly = 0; m_rest = 4;
        end else if (tick) begin
          nx = m_x + m_vx;
          ny = m_y + m_vy;
          if (nx < 0 || nx > 639 || ny < 0 || ny > 479) begin
            m_fly = 0; m_rest = 4;
          end else begin
            m_x = nx; m_y = ny;
          end
        end
      end else if (tick) begin
        m_rest = m_rest - 1;
      end
    end
  end

  // per-cycle comparison of all outputs against the model
  always @(negedge Clk) begin
    if (Reset) begin
      total++;
      if (int'(bus.bullet_x) != m_x || int'(bus.bullet_y) != m_y ||
          bus.bullet_active != m_fly || bus.ready != m_ready() ||
          int'(bus.shots_fired) != m_shots) begin
        bad++;
        $display("FAIL cycle_model t=%0t got x=%0d y=%0d act=%0b rdy=%0b shots=%0d want x=%0d y=%0d act=%0b rdy=%0b shots=%0d",
                 $time, bus.bullet_x, bus.bullet_y, bus.bullet_active, bus.ready, bus.shots_fired,
                 m_x, m_y, m_fly, m_ready(), m_shots);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  // one frame pulse; the tick acts on the third Clk edge, optionally with a coincident hit
  task automatic frame(input bit with_hit);
    @(negedge Clk) bus.frame_clk = 1'b1;
    @(negedge Clk);
    @(negedge Clk) bus.hit = with_hit;
    @(negedge Clk) begin bus.hit = 1'b0; bus.frame_clk = 1'b0; end
    repeat (3) @(negedge Clk);
  endtask

  // release then re-press the fire key; fire_req lands on the next Clk edge
  task automatic press();
    @(negedge Clk) bus.keycode = 8'h00;
    @(negedge Clk) bus.keycode = 8'h2C;
  endtask

  function automatic int pick_pos(input int lim);
    case ($urandom_range(0, 3))
      0:       return 0;
      1:       return lim;
      default: return int'($urandom_range(0, lim));
    endcase
  endfunction

  function automatic logic [9:0] pick_motion();
    int m;
    if ($urandom_range(0, 7) == 0) return 10'($urandom);
    m = int'($urandom_range(0, 60)) - 30;
    return 10'(m);
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fcnt, fper;
    bus.frame_clk = 1'b0; bus.keycode = 8'h00; bus.hit = 1'b0;
    bus.init_pos_x = '0; bus.init_pos_y = '0; bus.motion_x = '0; bus.motion_y = '0;
    repeat (3) @(negedge Clk);
    chk("rst_ready", int'(bus.ready), 1);
    chk("rst_active", int'(bus.bullet_active), 0);
    chk("rst_shots", int'(bus.shots_fired), 0);
    chk("rst_x", int'(bus.bullet_x), 0);
    Reset = 1'b1;

    // launch with key held
    @(negedge Clk);
    bus.keycode = 8'h2C;
    bus.init_pos_x = 10'd85; bus.init_pos_y = 10'd40;
    bus.motion_x = 10'd2; bus.motion_y = 10'd0;
    @(negedge Clk);
    chk("launch_active", int'(bus.bullet_active), 1);
    chk("launch_x", int'(bus.bullet_x), 85);
    chk("launch_y", int'(bus.bullet_y), 40);
    chk("launch_shots", int'(bus.shots_fired), 1);
    chk("launch_ready", int'(bus.ready), 0);

    repeat (3) frame(1'b0);
    chk("flight3_x", int'(bus.bullet_x), 97);
    chk("flight3_y", int'(bus.bullet_y), 40);
    chk("held_key_shots", int'(bus.shots_fired), 1);

    // turret moves mid-flight, then a hit coincides with a tick
    bus.motion_x = 10'd1; bus.init_pos_x = 10'd300;
    frame(1'b1);
    chk("hit_active", int'(bus.bullet_active), 0);
    chk("hit_x", int'(bus.bullet_x), 97);
    chk("hit_y", int'(bus.bullet_y), 40);
    chk("hit_ready", int'(bus.ready), 0);

    for (int k = 1; k <= 3; k++) begin
      press();
      frame(1'b0);
      chk("cool_ready", int'(bus.ready), 0);
      chk("cool_shots", int'(bus.shots_fired), 1);
    end
    frame(1'b0);
    chk("cool_done_ready", int'(bus.ready), 1);

    // upward shot off the top edge
    bus.init_pos_x = 10'd38; bus.init_pos_y = 10'd42;
    bus.motion_x = 10'd0; bus.motion_y = 10'h3FE;
    press();
    @(negedge Clk);
    chk("relaunch_shots", int'(bus.shots_fired), 2);
    chk("relaunch_y", int'(bus.bullet_y), 42);
    for (int k = 1; k <= 10; k++) begin
      frame(1'b0);
      chk("up_y", int'(bus.bullet_y), 42 - 4 * k);
    end
    frame(1'b0);
    chk("exit_active", int'(bus.bullet_active), 0);
    chk("exit_y", int'(bus.bullet_y), 2);
    chk("exit_x", int'(bus.bullet_x), 38);
    chk("exit_ready", int'(bus.ready), 0);
    repeat (4) frame(1'b0);
    chk("exit_cool_ready", int'(bus.ready), 1);

    // asynchronous reset mid-flight
    bus.init_pos_x = 10'd85; bus.init_pos_y = 10'd40;
    bus.motion_x = 10'd2; bus.motion_y = 10'd0;
    press();
    @(negedge Clk);
    chk("third_shots", int'(bus.shots_fired), 3);
    frame(1'b0);
    frame(1'b0);
    chk("third_x", int'(bus.bullet_x), 93);
    @(posedge Clk);
    #7 Reset = 1'b0;
    #1;
    chk("async_active", int'(bus.bullet_active), 0);
    chk("async_x", int'(bus.bullet_x), 0);
    chk("async_y", int'(bus.bullet_y), 0);
    chk("async_shots", int'(bus.shots_fired), 0);
    chk("async_ready", int'(bus.ready), 1);
    @(negedge Clk) begin Reset = 1'b1; bus.keycode = 8'h00; end

    // randomized traffic
    fcnt = 0; fper = 8;
    for (int c = 0; c < 3000; c++) begin
      @(negedge Clk);
      fcnt++;
      if (fcnt >= fper) begin fcnt = 0; fper = int'($urandom_range(4, 14)); end
      bus.frame_clk = (fcnt < 2);
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 3))
          0:       bus.keycode = 8'h00;
          3:       bus.keycode = 8'($urandom);
          default: bus.keycode = 8'h2C;
        endcase
      end
      bus.hit = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 15) == 0) begin
        bus.init_pos_x = 10'(pick_pos(639));
        bus.init_pos_y = 10'(pick_pos(479));
        bus.motion_x = pick_motion();
        bus.motion_y = pick_motion();
      end
    end
    @(negedge Clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
